// File: rtl/lpc_host_arb.sv
// lpc_host_arb: two-requester LPC I/O cycle master.
// Round-robin grant, SYNC wait handling with timeout abort.
module lpc_host_arb #(
    parameter int SYNC_TIMEOUT = 8
) (
    input  logic        lpc_clk,
    input  logic        lpc_rst,
    output logic        lpc_frame,
    output logic [3:0]  lpc_data_out,
    output logic        lpc_data_oe,
    input  logic [3:0]  lpc_data_in,
    input  logic        req0_valid,
    input  logic        req0_wr,
    input  logic [15:0] req0_addr,
    input  logic [7:0]  req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_wr,
    input  logic [15:0] req1_addr,
    input  logic [7:0]  req1_wdata,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [3:0] {
        IDLE, START, CTDIR, ADDR, WDATA, HTAR0,
        HTAR1, SYNC, RDATA, PTAR0, PTAR1, ABORT
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [3:0]  wcnt;
    logic [3:0]  wcnt_inc;
    logic [23:0] sh;
    logic [7:0]  rdata_q;
    logic        wr_q;
    logic        err_q;
    logic        cur_id;
    logic        last_id;
    logic        gnt;
    logic        gnt_id;

    always_comb begin
        gnt      = req0_valid | req1_valid;
        gnt_id   = (req0_valid && req1_valid) ? ~last_id : req1_valid;
        wcnt_inc = (wcnt == 4'hF) ? wcnt : wcnt + 4'd1;
    end

    always_ff @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            state        <= IDLE;
            lpc_frame    <= 1'b1;
            lpc_data_oe  <= 1'b0;
            lpc_data_out <= 4'hF;
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 8'hFF;
            last_id      <= 1'b1;
            cur_id       <= 1'b0;
            wcnt         <= 4'd0;
            cnt          <= 2'd0;
            sh           <= 24'd0;
            rdata_q      <= 8'd0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp_valid  <= 1'b0;
            unique case (state)
                IDLE: if (gnt) begin
                    req0_ready   <= ~gnt_id;
                    req1_ready   <= gnt_id;
                    cur_id       <= gnt_id;
                    last_id      <= gnt_id;
                    wr_q         <= gnt_id ? req1_wr : req0_wr;
                    // address nibbles then wdata low/high, shifted out MSB first
                    sh           <= gnt_id ?
                        {req1_addr, req1_wdata[3:0], req1_wdata[7:4]} :
                        {req0_addr, req0_wdata[3:0], req0_wdata[7:4]};
                    wcnt         <= 4'd0;
                    err_q        <= 1'b0;
                    cnt          <= 2'd0;
                    lpc_frame    <= 1'b0;
                    lpc_data_oe  <= 1'b1;
                    lpc_data_out <= 4'h0;
                    state        <= START;
                end
                START: begin
                    lpc_frame    <= 1'b1;
                    lpc_data_out <= wr_q ? 4'h2 : 4'h0;
                    state        <= CTDIR;
                end
                CTDIR: begin
                    lpc_data_out <= sh[23:20];
                    sh           <= sh << 4;
                    cnt          <= 2'd0;
                    state        <= ADDR;
                end
                ADDR: begin
                    cnt <= cnt + 2'd1;
                    if (cnt != 2'd3 || wr_q) begin
                        lpc_data_out <= sh[23:20];
                        sh           <= sh << 4;
                    end else begin
                        lpc_data_out <= 4'hF;
                    end
                    if (cnt == 2'd3)
                        state <= wr_q ? WDATA : HTAR0;
                end
                WDATA: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd0) begin
                        lpc_data_out <= sh[23:20];
                        sh           <= sh << 4;
                    end else begin
                        lpc_data_out <= 4'hF;
                        state        <= HTAR0;
                    end
                end
                HTAR0: begin
                    lpc_data_oe  <= 1'b0;
                    lpc_data_out <= 4'hF;
                    state        <= HTAR1;
                end
                HTAR1: state <= SYNC;
                SYNC: begin
                    case (lpc_data_in)
                        4'h0: begin
                            cnt   <= 2'd0;
                            state <= wr_q ? PTAR0 : RDATA;
                        end
                        4'h6: state <= SYNC;
                        4'hA: begin
                            err_q <= 1'b1;
                            state <= PTAR0;
                        end
                        default: begin
                            wcnt <= wcnt_inc;
                            if (int'(wcnt_inc) >= SYNC_TIMEOUT) begin
                                err_q       <= 1'b1;
                                cnt         <= 2'd0;
                                lpc_frame   <= 1'b0;
                                lpc_data_oe <= 1'b1;
                                state       <= ABORT;
                            end
                        end
                    endcase
                end
                RDATA: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd0) begin
                        rdata_q[3:0] <= lpc_data_in;
                    end else begin
                        rdata_q[7:4] <= lpc_data_in;
                        state        <= PTAR0;
                    end
                end
                PTAR0: state <= PTAR1;
                PTAR1: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    rsp_err   <= err_q;
                    rsp_rdata <= (wr_q || err_q) ? 8'hFF : rdata_q;
                    state     <= IDLE;
                end
                ABORT: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        lpc_frame   <= 1'b1;
                        lpc_data_oe <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cur_id;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= 8'hFF;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
